// File: rtl/sodor_trace_pkg.sv
// Shared types and widths for the per-core commit trace producer.
// A record captures one retiring instruction's control-flow and memory footprint.
package sodor_trace_pkg;

    localparam int XLEN    = 32;
    localparam int PCSEL_W = 3;
    localparam int SEQ_W   = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FREEZE  = 2'd1,
        DRAINED = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc_next;
        logic [PCSEL_W-1:0] pc_sel;
        logic               mem_valid;
        logic [XLEN-1:0]    addr;
        logic [SEQ_W-1:0]   seq;
    } commit_rec_t;

    // Address is only meaningful with a live dmem request, so it is zeroed otherwise.
    function automatic commit_rec_t make_rec(
        input logic [XLEN-1:0]    pc_next,
        input logic [PCSEL_W-1:0] pc_sel,
        input logic               mem_valid,
        input logic [XLEN-1:0]    addr,
        input logic [SEQ_W-1:0]   seq
    );
        commit_rec_t r;
        r.pc_next   = pc_next;
        r.pc_sel    = pc_sel;
        r.mem_valid = mem_valid;
        r.addr      = mem_valid ? addr : '0;
        r.seq       = seq;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH-entry FIFO of commit records; head entry is visible combinationally.
// Caller guarantees no pop when empty and no push when full without a pop.
module trace_fifo
    import sodor_trace_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  commit_rec_t          wdata_i,
    output commit_rec_t          rdata_o,
    output logic [DEPTH_LOG:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);

    commit_rec_t            mem_q [DEPTH];
    logic [DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]     count_q,  count_d;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/sodor_commit_trace_tx.sv
// Producer side of the dual-core commit comparison link: captures commit records,
// buffers them, and supports a freeze/drain sequence after a downstream deviation.
module sodor_commit_trace_tx
    import sodor_trace_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc_next,
    input  logic [PCSEL_W-1:0] commit_pc_sel,
    input  logic               commit_mem_valid,
    input  logic [XLEN-1:0]    commit_mem_addr,
    output logic               core_stall,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc_next,
    output logic [PCSEL_W-1:0] out_pc_sel,
    output logic               out_mem_valid,
    output logic [XLEN-1:0]    out_mem_addr,
    output logic [SEQ_W-1:0]   out_seq,
    input  logic               freeze,
    output logic               drained,
    output logic               overflow,
    output logic [SEQ_W-1:0]   dropped_cnt
);

    trace_state_e           state_q, state_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [SEQ_W-1:0]       dropped_q, dropped_d;
    logic                   overflow_q, overflow_d;
    logic                   drained_q, drained_d;

    logic [DEPTH_LOG:0]     count;
    logic                   full, empty;
    logic                   pop, push_req, push;
    commit_rec_t            head, wr_rec;

    assign out_valid = !empty && (state_q != DRAINED);
    assign pop       = out_valid && out_ready;
    // The commit in the cycle freeze is sampled is already excluded from capture.
    assign push_req  = commit_valid && (state_q == RUN) && !freeze;
    assign push      = push_req && (!full || pop);
    assign wr_rec    = make_rec(commit_pc_next, commit_pc_sel, commit_mem_valid,
                                commit_mem_addr, seq_q);

    trace_fifo #(
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d    = state_q;
        seq_d      = push ? seq_q + 1'b1 : seq_q;
        overflow_d = overflow_q | (push_req && full && !pop);
        dropped_d  = dropped_q;
        if ((state_q != RUN) && commit_valid && (dropped_q != '1)) begin
            dropped_d = dropped_q + 1'b1;
        end
        case (state_q)
            RUN:     if (freeze) state_d = FREEZE;
            FREEZE:  if ((count == '0) || ((count == 1) && pop)) state_d = DRAINED;
            DRAINED: state_d = DRAINED;
            default: state_d = RUN;
        endcase
        drained_d = drained_q | (state_d == DRAINED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            seq_q      <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
            drained_q  <= drained_d;
        end
    end

    // Stall comes from registered occupancy and state only; out_ready never reaches it.
    assign core_stall    = full && (state_q == RUN);
    assign drained       = drained_q;
    assign overflow      = overflow_q;
    assign dropped_cnt   = dropped_q;

    assign out_pc_next   = out_valid ? head.pc_next   : '0;
    assign out_pc_sel    = out_valid ? head.pc_sel    : '0;
    assign out_mem_valid = out_valid ? head.mem_valid : 1'b0;
    assign out_mem_addr  = out_valid ? head.addr      : '0;
    assign out_seq       = out_valid ? head.seq       : '0;

endmodule
